// File: rtl/seg_debug_mon_pkg.sv
// Shared definitions for the seg_debug_mon debug display:
// segment constants, hex-to-7-segment encoding and derived-size helpers.
package seg_debug_mon_pkg;

    // Active-low segments, bit 0 = segment a ... bit 6 = segment g
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    // Active-low encoding of one hex nibble
    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Number of display pages needed to show a dw-bit word on ndig digits
    function automatic int calc_npage(input int dw, input int ndig);
        return (dw + 4 * ndig - 1) / (4 * ndig);
    endfunction

    // Index width for n items, never narrower than one bit
    function automatic int calc_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_debug_mon_key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// one-cycle press pulse on the released->pressed transition.
// Raw edge to press pulse is 2 + DB_CYCLES clock cycles; any bounce
// back to the current state restarts the stability count.
module seg_debug_mon_key_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_press
);

    localparam int CNTW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DB_CYCLES - 1);

    logic            r_s1;
    logic            r_s2;
    logic            r_pressed;
    logic            r_press;
    logic [CNTW-1:0] r_cnt;
    logic            w_sample_pressed;

    assign w_sample_pressed = ~r_s2;
    assign o_press          = r_press;

    // Synchronise the raw key, count consecutive differing samples, flip state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= 1'b1;
            r_s2      <= 1'b1;
            r_pressed <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_s1    <= i_key_n;
            r_s2    <= r_s1;
            r_press <= 1'b0;
            if (w_sample_pressed != r_pressed) begin
                if (r_cnt == CNT_LAST) begin
                    r_pressed <= w_sample_pressed;
                    r_press   <= w_sample_pressed;
                    r_cnt     <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/seg_debug_mon.sv
// Multi-channel debug monitor for the 7-segment bank. Captures one of NCH
// debug words into a shadow register and shows one page of it on NDIG
// digits; debounced keys step the channel, step the page and toggle freeze.
// Optional build macro SEG_DBG_LZ_BLANK_EN: blank leading-zero digits.
module seg_debug_mon
    import seg_debug_mon_pkg::*;
#(
    parameter  int NCH        = 3,
    parameter  int DW         = 32,
    parameter  int NDIG       = 6,
    parameter  int DB_CYCLES  = 500000,
    parameter  int BLINK_LOG2 = 24,
    localparam int NPAGE      = calc_npage(DW, NDIG),
    localparam int CW         = calc_w(NCH),
    localparam int PW         = calc_w(NPAGE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH*DW-1:0] ch_data,
    input  logic [NCH-1:0]    ch_valid,
    input  logic              key_next_n,
    input  logic              key_page_n,
    input  logic              key_frz_n,
    output logic [NDIG*7-1:0] hex,
    output logic [CW-1:0]     ch_sel,
    output logic [PW-1:0]     page,
    output logic              frozen
);

    localparam int            NNIB    = DW / 4;
    localparam logic [CW-1:0] CH_LAST = CW'(NCH - 1);
    localparam logic [PW-1:0] PG_LAST = PW'(NPAGE - 1);

    // Reset image: "0" on digits that map into the word, blank beyond it
    function automatic logic [NDIG*7-1:0] hex_reset_image();
        logic [NDIG*7-1:0] img;
        for (int d = 0; d < NDIG; d++) begin
            img[d*7 +: 7] = (d < NNIB) ? SEG_ZERO : SEG_BLANK;
        end
        return img;
    endfunction

    localparam logic [NDIG*7-1:0] HEX_RST = hex_reset_image();

    logic                  w_press_next;
    logic                  w_press_page;
    logic                  w_press_frz;
    logic [CW-1:0]         r_ch_sel;
    logic [PW-1:0]         r_page;
    logic                  r_frozen;
    logic [DW-1:0]         r_shadow;
    logic [BLINK_LOG2-1:0] r_blink;
    logic [NDIG*7-1:0]     r_hex;
    logic [CW-1:0]         w_ch_nxt;
    logic [DW-1:0]         w_nxt_word;
    logic [DW-1:0]         w_cur_word;
    logic [NDIG*7-1:0]     w_hex_nxt;

    seg_debug_mon_key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_key_n (key_next_n),
        .o_press (w_press_next)
    );

    seg_debug_mon_key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_page (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_key_n (key_page_n),
        .o_press (w_press_page)
    );

    seg_debug_mon_key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_frz (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_key_n (key_frz_n),
        .o_press (w_press_frz)
    );

    assign w_ch_nxt   = (r_ch_sel == CH_LAST) ? '0 : r_ch_sel + 1'b1;
    assign w_nxt_word = ch_data[w_ch_nxt*DW +: DW];
    assign w_cur_word = ch_data[r_ch_sel*DW +: DW];

    assign hex    = r_hex;
    assign ch_sel = r_ch_sel;
    assign page   = r_page;
    assign frozen = r_frozen;

    // Channel/page/freeze selection; a channel step wins over page and freeze
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch_sel <= '0;
            r_page   <= '0;
            r_frozen <= 1'b0;
        end else if (w_press_next) begin
            r_ch_sel <= w_ch_nxt;
            r_page   <= '0;
            r_frozen <= 1'b0;
        end else begin
            if (w_press_page) begin
                r_page <= (r_page == PG_LAST) ? '0 : r_page + 1'b1;
            end
            if (w_press_frz) begin
                r_frozen <= ~r_frozen;
            end
        end
    end

    // Shadow word: load new channel on switch, else follow the selected strobe unless frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (w_press_next) begin
            r_shadow <= w_nxt_word;
        end else if (!r_frozen && ch_valid[r_ch_sel]) begin
            r_shadow <= w_cur_word;
        end
    end

    // Free-running blink timebase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink <= '0;
        end else begin
            r_blink <= r_blink + 1'b1;
        end
    end

    // Per-digit nibble selection, encoding, leading-zero and blink blanking
    always_comb begin
        int            v_g;
        logic [DW-1:0] v_sh;
        logic [6:0]    v_seg;
`ifdef SEG_DBG_LZ_BLANK_EN
        int            v_top;
        v_top = 0;
        for (int i = 0; i < NNIB; i++) begin
            if (r_shadow[4*i +: 4] != 4'h0) begin
                v_top = i;
            end
        end
`endif
        w_hex_nxt = '0;
        v_g       = 0;
        v_sh      = '0;
        v_seg     = SEG_BLANK;
        for (int d = 0; d < NDIG; d++) begin
            v_g  = int'(r_page) * NDIG + d;
            v_sh = r_shadow >> (4 * v_g);
            if (v_g >= NNIB) begin
                v_seg = SEG_BLANK;
            end else begin
                v_seg = seg_encode(v_sh[3:0]);
            end
`ifdef SEG_DBG_LZ_BLANK_EN
            if (v_g > v_top) begin
                v_seg = SEG_BLANK;
            end
`endif
            if (r_frozen && r_blink[BLINK_LOG2-1]) begin
                v_seg = SEG_BLANK;
            end
            w_hex_nxt[d*7 +: 7] = v_seg;
        end
    end

    // Registered segment outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex <= HEX_RST;
        end else begin
            r_hex <= w_hex_nxt;
        end
    end

endmodule

// File: tb/tb_seg_debug_mon.sv
// Directed bench for seg_debug_mon with NCH=3, DW=32, NDIG=6,
// DB_CYCLES=4, BLINK_LOG2=4; expected segment images are hand-computed.
module tb_seg_debug_mon;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [95:0] ch_data = '0;
  logic [2:0]  ch_valid = '0;
  logic        key_next_n = 1'b1;
  logic        key_page_n = 1'b1;
  logic        key_frz_n = 1'b1;
  logic [41:0] hex;
  logic [1:0]  ch_sel;
  logic [0:0]  page;
  logic        frozen;

  int total = 0;
  int bad = 0;

  localparam logic [41:0] ALL_ZERO  = {6{7'h40}};
  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};
  localparam logic [41:0] ALL_F     = {6{7'h0E}};
  // 32'h1234ABCD page 0: 3 4 A B C D ; page 1: 1 2
  localparam logic [41:0] W0_P0 = {7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21};
  localparam logic [41:0] W0_P1 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24};
  // 32'h55667788 page 0: 6 6 7 7 8 8
  localparam logic [41:0] W1_P0 = {7'h02, 7'h02, 7'h78, 7'h78, 7'h00, 7'h00};
  // 32'h9900EEFF page 0: 0 0 E E F F
  localparam logic [41:0] W2_P0 = {7'h40, 7'h40, 7'h06, 7'h06, 7'h0E, 7'h0E};
`ifdef SEG_DBG_LZ_BLANK_EN
  localparam logic [41:0] A5_P0 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12};
  localparam logic [41:0] A5_P1 = {6{7'h7F}};
`else
  localparam logic [41:0] A5_P0 = {7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12};
  localparam logic [41:0] A5_P1 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40};
`endif

  seg_debug_mon #(
    .NCH        (3),
    .DW         (32),
    .NDIG       (6),
    .DB_CYCLES  (4),
    .BLINK_LOG2 (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .key_next_n (key_next_n),
    .key_page_n (key_page_n),
    .key_frz_n  (key_frz_n),
    .hex        (hex),
    .ch_sel     (ch_sel),
    .page       (page),
    .frozen     (frozen)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [31:0] w);
    ch_data[k*32 +: 32] = w;
  endtask

  task automatic pulse_valid(input int k);
    ch_valid[k] = 1'b1;
    tick(1);
    ch_valid = '0;
  endtask

  // 0 = next, 1 = page, 2 = freeze; hold long enough to register, then release
  task automatic press(input int which);
    case (which)
      0: key_next_n = 1'b0;
      1: key_page_n = 1'b0;
      default: key_frz_n = 1'b0;
    endcase
    tick(10);
    key_next_n = 1'b1;
    key_page_n = 1'b1;
    key_frz_n = 1'b1;
    tick(10);
  endtask

  initial begin
    int nb;
    int ns;

    // reset at start
    #2 rst_n = 1'b0;
    #1;
    chk("rst_hex", 64'(hex), 64'(ALL_ZERO));
    chk("rst_ch_sel", 64'(ch_sel), 64'd0);
    chk("rst_page", 64'(page), 64'd0);
    chk("rst_frozen", 64'(frozen), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // capture on ch0 and page stepping
    set_ch(0, 32'h1234ABCD);
    set_ch(1, 32'h55667788);
    set_ch(2, 32'h9900EEFF);
    pulse_valid(0);
    chk("cap_latency_hold", 64'(hex), 64'(ALL_ZERO));
    tick(1);
    chk("cap_ch0_p0", 64'(hex), 64'(W0_P0));
    press(1);
    chk("page_step", 64'(page), 64'd1);
    chk("cap_ch0_p1", 64'(hex), 64'(W0_P1));
    press(1);
    chk("page_wrap", 64'(page), 64'd0);
    chk("page_wrap_hex", 64'(hex), 64'(W0_P0));
    press(1);

    // channel stepping with wrap, page reset on switch
    press(0);
    chk("next1_ch_sel", 64'(ch_sel), 64'd1);
    chk("next1_page", 64'(page), 64'd0);
    chk("next1_hex", 64'(hex), 64'(W1_P0));
    press(0);
    chk("next2_ch_sel", 64'(ch_sel), 64'd2);
    chk("next2_hex", 64'(hex), 64'(W2_P0));
    press(0);
    chk("next3_wrap", 64'(ch_sel), 64'd0);
    chk("next3_hex", 64'(hex), 64'(W0_P0));

    // strobe of an unselected channel is ignored
    set_ch(1, 32'h00000000);
    pulse_valid(1);
    tick(2);
    chk("other_strobe_ignored", 64'(hex), 64'(W0_P0));

    // freeze: hold word, blink half of a 16-cycle period
    press(2);
    chk("frz_on", 64'(frozen), 64'd1);
    set_ch(0, 32'hFFFFFFFF);
    pulse_valid(0);
    tick(1);
    nb = 0;
    ns = 0;
    for (int i = 0; i < 16; i++) begin
      if (hex === ALL_BLANK) nb++;
      else if (hex === W0_P0) ns++;
      tick(1);
    end
    chk("frz_blank_cycles", 64'(nb), 64'd8);
    chk("frz_held_cycles", 64'(ns), 64'd8);
    press(1);
    chk("frz_page_step", 64'(page), 64'd1);
    chk("frz_still_frozen", 64'(frozen), 64'd1);
    press(1);
    press(2);
    chk("frz_off", 64'(frozen), 64'd0);
    ns = 0;
    for (int i = 0; i < 16; i++) begin
      if (hex === W0_P0) ns++;
      tick(1);
    end
    chk("unfrz_no_blank", 64'(ns), 64'd16);
    pulse_valid(0);
    tick(1);
    chk("unfrz_capture", 64'(hex), 64'(ALL_F));

    // bouncing next key: only the final stable press counts
    for (int i = 0; i < 10; i++) begin
      key_next_n = ~key_next_n;
      tick(2);
    end
    chk("bounce_no_step", 64'(ch_sel), 64'd0);
    press(0);
    chk("bounce_one_step", 64'(ch_sel), 64'd1);
    chk("bounce_hex", 64'(hex), 64'(ALL_ZERO));

    // asynchronous reset in the middle of activity
    press(2);
    press(1);
    chk("pre_rst_frozen", 64'(frozen), 64'd1);
    chk("pre_rst_page", 64'(page), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_hex", 64'(hex), 64'(ALL_ZERO));
    chk("mid_rst_ch_sel", 64'(ch_sel), 64'd0);
    chk("mid_rst_page", 64'(page), 64'd0);
    chk("mid_rst_frozen", 64'(frozen), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // small word: leading-zero handling on both pages
    set_ch(0, 32'h000000A5);
    pulse_valid(0);
    tick(1);
    chk("a5_p0", 64'(hex), 64'(A5_P0));
    press(1);
    chk("a5_p1", 64'(hex), 64'(A5_P1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
